// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-neuron datapath (synapse front end and LIF neuron).
package snn_pkg;

  localparam int unsigned CUR_WIDTH_DEF = 16;
  localparam int unsigned W_WIDTH_DEF   = 8;
  // Wide enough to hold any pre-clamp current for CUR_WIDTH up to 32 and N_SYN up to 16.
  localparam int unsigned CLAMP_W       = 40;

  typedef enum logic {
    ST_CONFIG = 1'b0,
    ST_RUN    = 1'b1
  } state_e;

  // Clamp a signed value into the unsigned range [0, 2^cur_w - 1].
  function automatic logic signed [CLAMP_W-1:0] sat_clamp(
    input logic signed [CLAMP_W-1:0] x,
    input int unsigned               cur_w
  );
    logic signed [CLAMP_W-1:0] max_v;
    max_v = $signed((CLAMP_W'(1) << cur_w) - CLAMP_W'(1));
    if (x[CLAMP_W-1]) begin
      return '0;
    end else if (x > max_v) begin
      return max_v;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/synapse_current_gen_sum.sv
// Masked signed sum of the synapse weights whose spike line is set.
module syn_weight_sum
  import snn_pkg::*;
#(
  parameter int unsigned N_SYN   = 4,
  parameter int unsigned W_WIDTH = W_WIDTH_DEF,
  parameter int unsigned SUM_W   = CUR_WIDTH_DEF + 4
) (
  input  logic [N_SYN*W_WIDTH-1:0] i_weights,
  input  logic [N_SYN-1:0]         i_mask,
  output logic signed [SUM_W-1:0]  o_sum
);

  always_comb begin
    o_sum = '0;
    for (int i = 0; i < int'(N_SYN); i++) begin
      if (i_mask[i]) begin
        o_sum = o_sum + SUM_W'($signed(i_weights[i*W_WIDTH +: W_WIDTH]));
      end
    end
  end

endmodule

// File: rtl/synapse_current_gen.sv
// Synaptic current generator: weight RAM loaded in CONFIG, leaky spike-weighted accumulator in RUN.
module synapse_current_gen
  import snn_pkg::*;
#(
  parameter int unsigned N_SYN       = 4,
  parameter int unsigned W_WIDTH     = W_WIDTH_DEF,
  parameter int unsigned CUR_WIDTH   = CUR_WIDTH_DEF,
  parameter int unsigned DECAY_SHIFT = 2,
  localparam int unsigned A_W        = (N_SYN > 1) ? $clog2(N_SYN) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_SYN-1:0]     spike_in,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [A_W-1:0]       w_addr,
  input  logic [W_WIDTH-1:0]   w_data,
  output logic                 running,
  output logic [CUR_WIDTH-1:0] current,
  output logic                 sat
);

  localparam int unsigned SUM_W = CUR_WIDTH + $clog2(N_SYN) + 2;

  state_e                      r_state;
  state_e                      w_state_nxt;
  logic signed [W_WIDTH-1:0]   r_weight [N_SYN];
  logic [N_SYN*W_WIDTH-1:0]    w_weights_flat;
  logic signed [SUM_W-1:0]     w_sum;
  logic [CUR_WIDTH-1:0]        r_current;
  logic                        r_sat;
  logic [CUR_WIDTH-1:0]        w_leak;
  logic signed [SUM_W-1:0]     w_next;
  logic signed [CLAMP_W-1:0]   w_next_ext;
  logic [CUR_WIDTH-1:0]        w_cur_nxt;
  logic                        w_sat_nxt;
  logic                        w_wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CONFIG;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stop has priority over start; each is only honoured in the opposite state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CONFIG: if (start && !stop) w_state_nxt = ST_RUN;
      ST_RUN:    if (stop)           w_state_nxt = ST_CONFIG;
      default:   w_state_nxt = ST_CONFIG;
    endcase
  end

  assign w_ready = (r_state == ST_CONFIG);
  assign running = (r_state == ST_RUN);
  assign w_wr_en = w_valid && w_ready && (32'(w_addr) < N_SYN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_SYN); i++) r_weight[i] <= '0;
    end else if (w_wr_en) begin
      r_weight[w_addr] <= w_data;
    end
  end

  always_comb begin
    w_weights_flat = '0;
    for (int i = 0; i < int'(N_SYN); i++) begin
      w_weights_flat[i*W_WIDTH +: W_WIDTH] = r_weight[i];
    end
  end

  syn_weight_sum #(
    .N_SYN   (N_SYN),
    .W_WIDTH (W_WIDTH),
    .SUM_W   (SUM_W)
  ) u_sum (
    .i_weights (w_weights_flat),
    .i_mask    (spike_in),
    .o_sum     (w_sum)
  );

  // Leak floors at 1 so a small non-zero current always decays to 0.
  always_comb begin
    w_leak = r_current >> DECAY_SHIFT;
    if ((w_leak == '0) && (r_current != '0)) begin
      w_leak = CUR_WIDTH'(1);
    end
    w_next     = $signed({{(SUM_W-CUR_WIDTH){1'b0}}, r_current})
               - $signed({{(SUM_W-CUR_WIDTH){1'b0}}, w_leak})
               + w_sum;
    w_next_ext = CLAMP_W'(w_next);
    w_cur_nxt  = CUR_WIDTH'(sat_clamp(w_next_ext, CUR_WIDTH));
    w_sat_nxt  = (w_next_ext != $signed(CLAMP_W'(w_cur_nxt)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_current <= '0;
      r_sat     <= 1'b0;
    end else if ((r_state == ST_RUN) && !stop) begin
      r_current <= w_cur_nxt;
      r_sat     <= w_sat_nxt;
    end else begin
      r_current <= '0;
      r_sat     <= 1'b0;
    end
  end

  assign current = r_current;
  assign sat     = r_sat;

endmodule
